instruction_fetch_queue: RTL

// Parametrised, decoupled instruction-fetch front end for the RV32I pipeline.
// - Generates sequential PCs and issues reads to a 1-cycle-latency instruction memory.
// - Buffers returned words with their PCs in a DEPTH-entry FIFO.
// - Presents them to decode over a valid/ready handshake.
// - A redirect from decode (taken branch/jump) flushes the queue and discards in-flight reads.

---
 rtl/instruction_fetch_queue.sv | 117 +++++++++++
 1 files changed

// File: rtl/instruction_fetch_queue.sv
// Decoupled RV32I fetch front end: sequential PC generation, 1-cycle IMEM reads,
// DEPTH-entry instruction/PC FIFO to decode, redirect flush with epoch-tagged responses.
module instruction_fetch_queue #(
  parameter int          XLEN     = 32,
  parameter int          PC_WIDTH = 9,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic [PC_WIDTH-3:0]        imem_address,
  output logic                       imem_read,
  input  logic [XLEN-1:0]            imem_data,
  input  logic                       redirect,
  input  logic [PC_WIDTH-1:0]        redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_instruction,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]       count_q, count_d;
  logic [AW-1:0]       head_q, head_d;
  logic [AW-1:0]       tail_q, tail_d;
  logic                pending_q, pending_d;
  logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                pend_epoch_q, pend_epoch_d;
  logic                epoch_q, epoch_d;

  logic [XLEN-1:0]     instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];

  logic                redirect_act;
  logic                pop;
  logic                push;
  logic                issue_ok;
  logic [CW:0]         credits_used;

  assign redirect_act = reset & redirect;
  assign out_valid    = (count_q != '0);
  assign pop          = out_valid & out_ready;
  // Counting the outstanding read and this cycle's pop guarantees a push never meets a full FIFO.
  assign credits_used = {1'b0, count_q} + (CW+1)'(pending_q) - (CW+1)'(pop);
  assign issue_ok     = (credits_used < (CW+1)'(DEPTH));
  // A response issued before a redirect carries the old epoch (or lands in the redirect cycle) and is dropped.
  assign push         = reset & pending_q & (pend_epoch_q == epoch_q) & ~redirect_act;

  always_comb begin
    imem_read    = reset & (redirect_act | issue_ok);
    imem_address = redirect_act ? redirect_pc[PC_WIDTH-1:2] : fetch_pc_q[PC_WIDTH-1:2];
    fetch_pc_d   = fetch_pc_q;
    if (redirect_act) begin
      fetch_pc_d = {redirect_pc[PC_WIDTH-1:2], 2'b00} + PC_STEP;
    end else if (imem_read) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
    epoch_d      = epoch_q ^ redirect_act;
    pending_d    = imem_read;
    pend_pc_d    = {imem_address, 2'b00};
    pend_epoch_d = epoch_d;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_act) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(pop);
      tail_d  = tail_q + AW'(push);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc_q   <= RESET_PC_V;
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      pending_q    <= 1'b0;
      pend_pc_q    <= '0;
      pend_epoch_q <= 1'b0;
      epoch_q      <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      pending_q    <= pending_d;
      pend_pc_q    <= pend_pc_d;
      pend_epoch_q <= pend_epoch_d;
      epoch_q      <= epoch_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[tail_q] <= imem_data;
      pc_mem[tail_q]    <= pend_pc_q;
    end
  end

  assign out_instruction = out_valid ? instr_mem[head_q] : '0;
  assign out_pc          = out_valid ? pc_mem[head_q] : '0;
  assign count           = count_q;

endmodule
